serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder that feeds the team's one-bit `fullAdder` cell and consumes its outputs. It adds two WIDTH-bit operands LSB-first, one bit per clock. The carry is registered between bits, and the result is presented with a start/done handshake. It sits upstream of the full-adder cell as its sequencer and downstream of any operand source that uses a start/busy handshake.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 64.

Ports:
- clk, input, 1, single clock; all logic updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, request to begin an addition; sampled on each rising edge.
- a, input, WIDTH, operand A; captured on an accepted start.
- b, input, WIDTH, operand B; captured on an accepted start.
- cin, input, 1, carry-in; captured on an accepted start.
- busy, output, 1, high while bits are being computed.
- done, output, 1, one-cycle pulse when a new result becomes valid.
- sum, output, WIDTH, result register; holds the last completed sum.
- carryOut, output, 1, final carry of the last completed addition.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- Reset values:
  - State is IDLE.
  - busy=0, done=0, sum=0, carryOut=0.
  - The internal shift registers, carry register and bit counter are all 0.
- IDLE, with start=1:
  - Latch a and b into the operand shift registers and cin into the carry register.
  - Clear the bit counter and move to RUN.
- RUN, on each cycle:
  - Drive the `fullAdder` with the a0/b0 LSBs of the operand shift registers and with the carry register.
  - Shift the cell's sum bit into the MSB of the working sum register.
  - Shift both operand registers right by one.
  - Load the carry register with the cell's carryOut and increment the counter.
  - When the counter reaches WIDTH-1 on the current edge, that bit is the last one; move to DONE.
- Entering DONE:
  - Copy the working sum register to `sum` and the final carry to `carryOut`.
  - done=1 for exactly one cycle.
- DONE:
  - If start=1, accept new operands exactly as in IDLE and go to RUN. This gives back-to-back operation with no idle gap.
  - Otherwise go to IDLE.
- start while in RUN is ignored. No queueing takes place and the captured operands are unaffected.
- `sum` and `carryOut` change only when entering DONE. They stay stable throughout RUN, so the previous result stays readable.
- Arithmetic:
  - {carryOut, sum} = a + b + cin, modulo 2^(WIDTH+1).
  - The operands are treated as unsigned.
- rst asserted in any state returns the block to its reset values on that edge. Any addition in progress is discarded and no done is issued.

## Timing
- An accepted start is sampled at edge N.
- busy=1 during cycles N+1 through N+WIDTH; one bit is computed per edge.
- done=1 and the new sum/carryOut are valid in cycle N+WIDTH+1.
- Latency from start to done is WIDTH+1 cycles. Throughput is one addition per WIDTH+1 cycles when start is held or pulsed during DONE.
- busy=0 in IDLE and DONE.
- done is never high while busy=1.
- With WIDTH=1, RUN lasts one cycle and done appears at N+2.
- The `fullAdder` path is purely combinational between registers. The critical path is register -> cell -> register.

## Configuration
- Macro: SERIAL_ADDER_OVERFLOW_EN.
- Defined:
  - Adds the output `overflow` (output, 1), which indicates two's-complement signed overflow.
  - overflow = carry into the MSB XOR final carry. It is captured from the carry register and the cell's carryOut on the last RUN cycle.
  - It updates alongside `sum` on entry to DONE and resets to 0.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulsed at edge N -> busy during N+1..N+8; done at N+9 with sum=0x96, carryOut=0, and overflow=1 if the macro is enabled.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, carryOut=1, overflow=0; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, carryOut=1.
- Start pulsed again at N+3 while busy -> ignored; the result still matches the first operands, and exactly one done pulse occurs.
- start held high continuously with a=0x01, b=0x02 -> done pulses every 9 cycles with sum=0x03; sum holds the prior value during each RUN.
- rst asserted at N+4 mid-RUN -> the next cycle shows busy=0, done=0, sum=0, carryOut=0, and no done follows.
- WIDTH=1, a=1, b=1, cin=1 -> done two cycles after start with sum=1, carryOut=1.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one bit per clock.
// Operands are captured on an accepted start. A one-bit full-adder cell then consumes
// one bit per cycle, and the carry is registered between bits. The result is published
// on entry to DONE together with a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_OVERFLOW_EN to add the signed 'overflow' output.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             carryOut
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned MsbPos = WIDTH - 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  // One-bit full-adder cell fed by the operand LSBs and the carry register
  logic fa_a, fa_b, fa_sum, fa_cout;
  assign fa_a    = a_q[0];
  assign fa_b    = b_q[0];
  assign fa_sum  = fa_a ^ fa_b ^ carry_q;
  assign fa_cout = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        busy    = 1'b1;
        // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB
        acc_d   = (acc_q >> 1) | (WIDTH'(fa_sum) << MsbPos);
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          state_d = StDone;
          sum_d   = acc_d;
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          // On the last bit, carry_q is the carry into the MSB
          ovf_d   = carry_q ^ fa_cout;
`endif
        end
      end

      StDone: begin
        done = 1'b1;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum      = sum_q;
  assign carryOut = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder (WIDTH=8 and WIDTH=1)
// against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  logic         start1;
  logic [0:0]   a1, b1;
  logic         cin1;
  logic         busy1, done1;
  logic [0:0]   sum1;
  logic         cout1;

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         ovf, ovf1;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .overflow (ovf),
`endif
    .carryOut (cout)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start1),
    .a        (a1),
    .b        (b1),
    .cin      (cin1),
    .busy     (busy1),
    .done     (done1),
    .sum      (sum1),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .overflow (ovf1),
`endif
    .carryOut (cout1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] prev_sum;
  logic         prev_cout;
  logic         prev_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {carry, sum} = a + b + cin as plain unsigned arithmetic
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int unsigned s;
    s = int'(x) + int'(y) + int'(c);
    return (W+1)'(s);
  endfunction

  // Reference: signed result falls outside the W-bit two's-complement range
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  // One full WIDTH=8 transaction, checked cycle by cycle
  task automatic add8(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                      input string tag);
    logic [W:0] r;
    r = ref_add(av, bv, ci);
    start = 1'b1; a = av; b = bv; cin = ci;
    @(negedge clk);
    // Scramble inputs: captured operands must not follow them
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int k = 1; k <= int'(W); k++) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_nodone"}, done, 0);
      if (k == 1 || k == int'(W)) begin
        check({tag, "_sumhold"}, sum, prev_sum);
        check({tag, "_couthold"}, cout, prev_cout);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check({tag, "_ovfhold"}, ovf, prev_ovf);
`endif
      end
      @(negedge clk);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_idlebusy"}, busy, 0);
    check({tag, "_sum"}, sum, r[W-1:0]);
    check({tag, "_cout"}, cout, r[W]);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check({tag, "_ovf"}, ovf, ref_ovf(av, bv, ci));
    prev_ovf = ref_ovf(av, bv, ci);
`endif
    prev_sum  = r[W-1:0];
    prev_cout = r[W];
    @(negedge clk);
    check({tag, "_donepulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  // One WIDTH=1 transaction: RUN for one cycle, done at N+2
  task automatic add1(input logic av, input logic bv, input logic ci, input string tag);
    int unsigned s;
    s = int'(av) + int'(bv) + int'(ci);
    start1 = 1'b1; a1 = av; b1 = bv; cin1 = ci;
    @(negedge clk);
    start1 = 1'b0;
    check({tag, "_busy"}, busy1, 1);
    check({tag, "_nodone"}, done1, 0);
    @(negedge clk);
    check({tag, "_done"}, done1, 1);
    check({tag, "_sum"}, sum1, s & 1);
    check({tag, "_cout"}, cout1, s >> 1);
    @(negedge clk);
    check({tag, "_donepulse"}, done1, 0);
  endtask

  initial begin
    logic [W:0] r;
    int         ndone;
    int         done_k;
    bit         exp_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check("rst_ovf", ovf, 0);
`endif
    check("rst1_busy", busy1, 0);
    check("rst1_sum", sum1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors from the test plan
    add8(8'h5A, 8'h3C, 1'b0, "v5a3c");
    check("v5a3c_const", sum, 8'h96);
    add8(8'hFF, 8'h01, 1'b0, "vff01");
    check("vff01_const", {cout, sum}, 9'h100);
    add8(8'hFF, 8'hFF, 1'b1, "vffff1");
    check("vffff1_const", {cout, sum}, 9'h1FF);

    // Random vectors
    for (int i = 0; i < 24; i++) begin
      add8(W'($urandom), W'($urandom), 1'($urandom), "rand");
    end

    // start while busy is ignored: one done, result of the first operands
    r = ref_add(8'h12, 8'h34, 1'b1);
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; done_k = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        ndone++;
        done_k = k;
        check("ign_sum", sum, r[W-1:0]);
        check("ign_cout", cout, r[W]);
      end
      if (k == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("ign_ndone", ndone, 1);
    check("ign_donecycle", done_k, W + 1);
    prev_sum = r[W-1:0];

    // start held high: done every W+1 cycles, sum held during each RUN
    start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 3 * (int'(W) + 1); k++) begin
      exp_done = (k % (int'(W) + 1)) == 0;
      check("held_done", done, exp_done);
      check("held_busy", busy, !exp_done);
      check("held_sum", sum, (k < int'(W) + 1) ? prev_sum : 8'h03);
      if (k == 3 * (int'(W) + 1)) start = 1'b0;
      @(negedge clk);
    end
    check("held_idle_done", done, 0);
    check("held_idle_busy", busy, 0);

    // Reset mid-RUN discards the addition
    start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_sum", sum, 0);
    check("mrst_cout", cout, 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("mrst_nodone", ndone, 0);
    check("mrst_sumhold", sum, 0);

    // WIDTH=1 instance: every input combination
    add1(1'b1, 1'b1, 1'b1, "w1_111");
    for (int v = 0; v < 8; v++) begin
      add1(v[2], v[1], v[0], "w1_all");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
